// File: rtl/nvram_upload_reader.sv
// Streams a window of core RAM out through the hps_io upload port, pausing the
// CPU and holding the host off with ioctl_wait until each byte is valid.
module nvram_upload_reader #(
  parameter int unsigned              ADDR_W = 16,
  parameter int unsigned              INDEX  = 4,
  parameter logic [ADDR_W-1:0]        BASE   = ADDR_W'(16'hC800),
  parameter int unsigned              LEN    = 256,
  parameter int unsigned              RD_LAT = 2
) (
  input  logic              clk_sys,
  input  logic              RESET_n,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic [24:0]       ioctl_addr,
  input  logic              ioctl_rd,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              pause_req,
  input  logic              paused,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_data,
  output logic              busy
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_PAUSE, S_ISSUE, S_LAT, S_READY, S_ADV
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        din_q, din_d;
  logic              wait_q, wait_d;
  logic              pause_q, pause_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              rd_q, rd_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic sel;
  logic in_range;

  assign sel      = ioctl_upload & (ioctl_index == 8'(INDEX));
  assign in_range = ioctl_addr < 25'(LEN);

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    wait_d  = wait_q;
    pause_d = pause_q;
    raddr_d = raddr_q;
    rd_d    = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (sel) begin
          state_d = S_PAUSE;
          wait_d  = 1'b1;
          pause_d = 1'b1;
        end
      end
      S_PAUSE: begin
        wait_d = 1'b1;
        if (paused) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (in_range) begin
          raddr_d = BASE + ioctl_addr[ADDR_W-1:0];
          rd_d    = 1'b1;
          cnt_d   = CNT_W'(RD_LAT);
          state_d = S_LAT;
        end else begin
          din_d   = 8'hFF;
          wait_d  = 1'b0;
          state_d = S_READY;
        end
      end
      S_LAT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          din_d   = ram_data;
          wait_d  = 1'b0;
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (ioctl_rd) begin
          wait_d  = 1'b1;
          state_d = S_ADV;
        end
      end
      S_ADV: begin
        state_d = S_ISSUE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Losing the upload window aborts from anywhere, ahead of any other event
    if ((state_q != S_IDLE) && !sel) begin
      state_d = S_IDLE;
      pause_d = 1'b0;
      wait_d  = 1'b0;
      rd_d    = 1'b0;
      din_d   = din_q;
      raddr_d = raddr_q;
      cnt_d   = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= S_IDLE;
      din_q   <= 8'h00;
      wait_q  <= 1'b0;
      pause_q <= 1'b0;
      raddr_q <= '0;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      wait_q  <= wait_d;
      pause_q <= pause_d;
      raddr_q <= raddr_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign pause_req  = pause_q;
  assign ram_addr   = raddr_q;
  assign ram_rd     = rd_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_nvram_upload_reader.sv
// Directed bench: instance A uses defaults (index 4, BASE C800, RD_LAT 2);
// instance B uses index 5, BASE FFFF, RD_LAT 3.
module tb_nvram_upload_reader;

  logic        clk_sys = 1'b0;
  logic        RESET_n = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [24:0] ioctl_addr = '0;
  logic        ioctl_rd = 1'b0;
  logic        paused = 1'b0;

  logic [7:0]  din_a, din_b, ram_data_a, ram_data_b;
  logic        wait_a, wait_b, pause_a, pause_b, rd_a, rd_b, busy_a, busy_b;
  logic [15:0] raddr_a, raddr_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_sys = ~clk_sys;

  nvram_upload_reader u_a (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd),
    .ioctl_din(din_a), .ioctl_wait(wait_a), .pause_req(pause_a), .paused(paused),
    .ram_addr(raddr_a), .ram_rd(rd_a), .ram_data(ram_data_a), .busy(busy_a)
  );

  nvram_upload_reader #(.INDEX(5), .BASE(16'hFFFF), .RD_LAT(3)) u_b (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd),
    .ioctl_din(din_b), .ioctl_wait(wait_b), .pause_req(pause_b), .paused(paused),
    .ram_addr(raddr_b), .ram_rd(rd_b), .ram_data(ram_data_b), .busy(busy_b)
  );

  function automatic logic [7:0] ram_a_val(input logic [15:0] a);
    case (a)
      16'hC800: return 8'h11;
      16'hC801: return 8'h22;
      16'hC802: return 8'h33;
      default:  return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [7:0] ram_b_val(input logic [15:0] a);
    case (a)
      16'h0000: return 8'hC3;
      16'hFFFF: return 8'h3C;
      default:  return a[7:0] ^ 8'h96;
    endcase
  endfunction

  // RAM models: data is presented only in the single cycle the reader must capture it
  logic [1:0]  hist_a = '0, hist_b = '0;
  logic [15:0] ah_a0 = '0, ah_b0 = '0, ah_b1 = '0;
  always @(posedge clk_sys) begin
    hist_a <= {hist_a[0], rd_a};
    hist_b <= {hist_b[0], rd_b};
    ah_a0  <= raddr_a;
    ah_b0  <= raddr_b;
    ah_b1  <= ah_b0;
  end
  assign ram_data_a = hist_a[0] ? ram_a_val(ah_a0) : 8'hEE;
  assign ram_data_b = hist_b[1] ? ram_b_val(ah_b1) : 8'hEE;

  logic        use_b = 1'b0;
  logic [7:0]  o_din;
  logic        o_wait, o_pause, o_rd, o_busy;
  logic [15:0] o_raddr;
  assign o_din   = use_b ? din_b   : din_a;
  assign o_wait  = use_b ? wait_b  : wait_a;
  assign o_pause = use_b ? pause_b : pause_a;
  assign o_rd    = use_b ? rd_b    : rd_a;
  assign o_busy  = use_b ? busy_b  : busy_a;
  assign o_raddr = use_b ? raddr_b : raddr_a;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  din;
    int          nrd;
    logic [15:0] raddr;
    int          lat;
  } vec_t;

  vec_t va[7];
  vec_t vb[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Open a window and serve the first byte; returns ram_rd-to-ready distance
  task automatic open_session(input logic b, input logic [24:0] addr, input logic stray_rd,
                              output logic [7:0] din, output int nrd,
                              output logic [15:0] raddr, output int rd2rdy);
    int k;
    int rdk;
    k = 0; rdk = 0; nrd = 0; raddr = '0;
    @(negedge clk_sys);
    use_b = b;
    ioctl_upload = 1'b1;
    ioctl_index = b ? 8'd5 : 8'd4;
    ioctl_addr = addr;
    paused = 1'b0;
    @(negedge clk_sys);
    chk("pause_req_rise", 32'(o_pause), 32'd1);
    chk("wait_rise", 32'(o_wait), 32'd1);
    if (stray_rd) begin
      ioctl_rd = 1'b1;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      @(negedge clk_sys);
      chk("stray_rd_wait_held", 32'(o_wait), 32'd1);
    end
    paused = 1'b1;
    do begin
      @(negedge clk_sys);
      k++;
      if (o_rd) begin nrd++; raddr = o_raddr; rdk = k; end
    end while (o_wait && k < 40);
    if (k >= 40) chk("first_byte_timeout", 32'(k), 32'd0);
    din = o_din;
    rd2rdy = k - rdk;
  endtask

  // From READY: consume current byte, present next address, wait for next byte
  task automatic step_byte(input logic [24:0] next_addr, output logic [7:0] din,
                           output int lat, output int nrd, output logic [15:0] raddr);
    int k;
    k = 0; nrd = 0; raddr = '0;
    ioctl_rd = 1'b1;
    do begin
      @(negedge clk_sys);
      if (k == 0) begin ioctl_rd = 1'b0; ioctl_addr = next_addr; end
      k++;
      if (o_rd) begin nrd++; raddr = o_raddr; end
    end while (o_wait && k < 40);
    if (k >= 40) chk("step_timeout", 32'(k), 32'd0);
    din = o_din;
    lat = k;
  endtask

  task automatic close_session();
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    paused = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  initial begin
    logic [7:0]  din;
    logic [15:0] raddr;
    logic [7:0]  prev;
    int          nrd, lat, rd2rdy, k, bad;

    va[0] = '{addr: 25'd1,    din: 8'h22, nrd: 1, raddr: 16'hC801, lat: 5};
    va[1] = '{addr: 25'd2,    din: 8'h33, nrd: 1, raddr: 16'hC802, lat: 5};
    va[2] = '{addr: 25'd255,  din: 8'hA5, nrd: 1, raddr: 16'hC8FF, lat: 5};
    va[3] = '{addr: 25'd256,  din: 8'hFF, nrd: 0, raddr: 16'h0000, lat: 3};
    va[4] = '{addr: 25'd1000, din: 8'hFF, nrd: 0, raddr: 16'h0000, lat: 3};
    va[5] = '{addr: 25'd0,    din: 8'h11, nrd: 1, raddr: 16'hC800, lat: 5};
    va[6] = '{addr: 25'd257,  din: 8'hFF, nrd: 0, raddr: 16'h0000, lat: 3};
    vb[0] = '{addr: 25'd1,    din: 8'hC3, nrd: 1, raddr: 16'h0000, lat: 6};
    vb[1] = '{addr: 25'd2,    din: 8'h97, nrd: 1, raddr: 16'h0001, lat: 6};
    vb[2] = '{addr: 25'd300,  din: 8'hFF, nrd: 0, raddr: 16'h0000, lat: 3};

    // Reset values
    repeat (2) @(negedge clk_sys);
    chk("rst_din", 32'(din_a), 32'h00);
    chk("rst_wait_pause_rd_busy", {28'd0, wait_a, pause_a, rd_a, busy_a}, 32'd0);
    chk("rst_raddr", 32'(raddr_a), 32'd0);
    RESET_n = 1'b1;

    // Basic read and out-of-range bytes on instance A
    open_session(1'b0, 25'd0, 1'b0, din, nrd, raddr, rd2rdy);
    chk("a0_din", 32'(din), 32'h11);
    chk("a0_nrd", 32'(nrd), 32'd1);
    chk("a0_raddr", 32'(raddr), 32'hC800);
    chk("a0_rd2rdy", 32'(rd2rdy), 32'd2);
    for (int i = 0; i < 7; i++) begin
      step_byte(va[i].addr, din, lat, nrd, raddr);
      chk($sformatf("a_din[%0d]", i), 32'(din), 32'(va[i].din));
      chk($sformatf("a_nrd[%0d]", i), 32'(nrd), 32'(va[i].nrd));
      chk($sformatf("a_lat[%0d]", i), 32'(lat), 32'(va[i].lat));
      if (va[i].nrd != 0) chk($sformatf("a_raddr[%0d]", i), 32'(raddr), 32'(va[i].raddr));
    end
    close_session();
    chk("a_closed", {29'd0, wait_a, pause_a, busy_a}, 32'd0);

    // Asynchronous reset while in LAT
    @(negedge clk_sys);
    use_b = 1'b0; ioctl_upload = 1'b1; ioctl_index = 8'd4; ioctl_addr = 25'd2;
    @(negedge clk_sys);
    paused = 1'b1;
    k = 0;
    do begin @(negedge clk_sys); k++; end while (!rd_a && k < 20);
    chk("rstlat_reached", 32'(rd_a), 32'd1);
    #2 RESET_n = 1'b0;
    #1;
    chk("rstlat_din", 32'(din_a), 32'h00);
    chk("rstlat_ctl", {28'd0, wait_a, pause_a, rd_a, busy_a}, 32'd0);
    chk("rstlat_raddr", 32'(raddr_a), 32'd0);
    ioctl_upload = 1'b0; paused = 1'b0;
    @(negedge clk_sys);
    RESET_n = 1'b1;
    bad = 0;
    repeat (5) begin @(negedge clk_sys); if (wait_a || busy_a) bad++; end
    chk("rstlat_release_idle", 32'(bad), 32'd0);

    // Wrong index never stalls the host
    @(negedge clk_sys);
    ioctl_upload = 1'b1; ioctl_index = 8'd0;
    bad = 0;
    repeat (100) begin
      @(negedge clk_sys);
      if (pause_a || wait_a || busy_a || pause_b || wait_b || busy_b) bad++;
    end
    chk("wrong_index_quiet", 32'(bad), 32'd0);
    ioctl_upload = 1'b0;

    // Abort during LAT: no late capture
    @(negedge clk_sys);
    prev = din_a;
    ioctl_upload = 1'b1; ioctl_index = 8'd4; ioctl_addr = 25'd1;
    @(negedge clk_sys);
    paused = 1'b1;
    k = 0;
    do begin @(negedge clk_sys); k++; end while (!rd_a && k < 20);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    chk("abort_ctl", {29'd0, wait_a, pause_a, busy_a}, 32'd0);
    chk("abort_din_kept", 32'(din_a), 32'(prev));
    bad = 0;
    repeat (6) begin @(negedge clk_sys); if (din_a !== prev || wait_a) bad++; end
    chk("abort_no_late_capture", 32'(bad), 32'd0);
    paused = 1'b0;

    // Instance B: stray strobe in PAUSE, RD_LAT=3 capture, address wrap
    open_session(1'b1, 25'd0, 1'b1, din, nrd, raddr, rd2rdy);
    chk("b0_din", 32'(din), 32'h3C);
    chk("b0_nrd", 32'(nrd), 32'd1);
    chk("b0_raddr", 32'(raddr), 32'hFFFF);
    chk("b0_rd2rdy", 32'(rd2rdy), 32'd3);
    for (int i = 0; i < 3; i++) begin
      step_byte(vb[i].addr, din, lat, nrd, raddr);
      chk($sformatf("b_din[%0d]", i), 32'(din), 32'(vb[i].din));
      chk($sformatf("b_nrd[%0d]", i), 32'(nrd), 32'(vb[i].nrd));
      chk($sformatf("b_lat[%0d]", i), 32'(lat), 32'(vb[i].lat));
      if (vb[i].nrd != 0) chk($sformatf("b_raddr[%0d]", i), 32'(raddr), 32'(vb[i].raddr));
    end
    close_session();
    chk("b_closed", {29'd0, wait_b, pause_b, busy_b}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
